// File: rtl/usb_rx_nrzi_unstuff.sv
// USB full-speed receive bit recovery: NRZI decode, bit-stuff removal and stuff-error
// detection, producing a qualified serial bit stream with a byte-boundary strobe.
module usb_rx_nrzi_unstuff #(
    parameter int unsigned STUFF_LEN = 6,
    parameter logic        IDLE_LINE = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic d_line,
    input  logic sample_en,
    input  logic rx_active,
    input  logic clear,
    output logic din_out,
    output logic bit_valid,
    output logic byte_done,
    output logic stuff_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        STUFF   = 2'd2
    } state_t;

    localparam logic [3:0] LP_STUFF_LEN = 4'(STUFF_LEN);

    state_t     r_state;
    logic       r_prev_line;
    logic [3:0] r_ones_cnt;
    logic [2:0] r_bit_cnt;
    logic       r_din;
    logic       r_bit_valid;
    logic       r_byte_done;
    logic       r_stuff_error;

    state_t     w_state_nxt;
    logic       w_prev_line_nxt;
    logic [3:0] w_ones_cnt_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_din_nxt;
    logic       w_bit_valid_nxt;
    logic       w_byte_done_nxt;
    logic       w_stuff_error_nxt;
    logic       w_stuff_set;
    logic       w_decoded;
    logic [3:0] w_ones_inc;

    assign w_decoded  = (d_line == r_prev_line);
    assign w_ones_inc = r_ones_cnt + 4'd1;

    always_comb begin
        w_state_nxt       = r_state;
        w_prev_line_nxt   = r_prev_line;
        w_ones_cnt_nxt    = r_ones_cnt;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_din_nxt         = r_din;
        w_bit_valid_nxt   = 1'b0;
        w_byte_done_nxt   = 1'b0;
        w_stuff_set       = 1'b0;
        w_stuff_error_nxt = r_stuff_error;

        if (!rx_active) begin
            w_state_nxt     = IDLE;
            w_prev_line_nxt = IDLE_LINE;
            w_ones_cnt_nxt  = 4'd0;
            w_bit_cnt_nxt   = 3'd0;
        end else begin
            unique case (r_state)
                // IDLE already holds the line/counter reset values, so the sample
                // arriving with rx_active is processed exactly like one in RECEIVE.
                IDLE, RECEIVE: begin
                    w_state_nxt = RECEIVE;
                    if (sample_en) begin
                        w_prev_line_nxt = d_line;
                        w_din_nxt       = w_decoded;
                        w_bit_valid_nxt = 1'b1;
                        w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
                        w_byte_done_nxt = (r_bit_cnt == 3'd7);
                        if (w_decoded) begin
                            w_ones_cnt_nxt = w_ones_inc;
                            if (w_ones_inc == LP_STUFF_LEN) begin
                                w_state_nxt = STUFF;
                            end
                        end else begin
                            w_ones_cnt_nxt = 4'd0;
                        end
                    end
                end
                STUFF: begin
                    if (sample_en) begin
                        w_prev_line_nxt = d_line;
                        w_ones_cnt_nxt  = 4'd0;
                        w_state_nxt     = RECEIVE;
                        w_stuff_set     = w_decoded;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        if (clear) begin
            w_bit_cnt_nxt     = 3'd0;
            w_stuff_error_nxt = 1'b0;
        end
        if (w_stuff_set) begin
            w_stuff_error_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state       <= IDLE;
            r_prev_line   <= IDLE_LINE;
            r_ones_cnt    <= 4'd0;
            r_bit_cnt     <= 3'd0;
            r_din         <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_byte_done   <= 1'b0;
            r_stuff_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_line   <= w_prev_line_nxt;
            r_ones_cnt    <= w_ones_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_din         <= w_din_nxt;
            r_bit_valid   <= w_bit_valid_nxt;
            r_byte_done   <= w_byte_done_nxt;
            r_stuff_error <= w_stuff_error_nxt;
        end
    end

    assign din_out     = r_din;
    assign bit_valid   = r_bit_valid;
    assign byte_done   = r_byte_done;
    assign stuff_error = r_stuff_error;

endmodule

// File: doc/usb_rx_nrzi_unstuff.md
Name: usb_rx_nrzi_unstuff

Overview:
Receive-side bit recovery stage for the USB full-speed packet path. It takes the sampled D+ line level once per bit period, NRZI-decodes it, removes stuffed bits and flags stuffing violations. It emits a qualified serial data bit stream with a byte-boundary strobe. It sits directly upstream of crc_checker_16bit, which takes din_out as its din, and of the receive shift register.

Parameters:
STUFF_LEN, 6, number of consecutive decoded ones after which the next bit must be a stuffed zero (valid range 2..15)
IDLE_LINE, 1, line level meaning J/idle; loaded into the previous-line register on reset and when rx_active is low

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
d_line  input  1  synchronized D+ level, sampled when sample_en is high
sample_en  input  1  one-cycle strobe, one per bit period, from the upstream edge/timing block
rx_active  input  1  high from sync detection until after EOP; low forces IDLE
clear  input  1  synchronous clear of sticky stuff_error and the bit counter
din_out  output  1  decoded, unstuffed data bit; holds its value between valid pulses
bit_valid  output  1  one-cycle pulse: din_out carries a new data bit
byte_done  output  1  one-cycle pulse, coincident with bit_valid, on every 8th emitted bit
stuff_error  output  1  sticky: STUFF_LEN+1 consecutive ones decoded

Behaviour:
- Reset, asynchronous: din_out=0, bit_valid=0, byte_done=0, stuff_error=0, prev_line=IDLE_LINE, ones_cnt=0, bit_cnt=0, state=IDLE.
- NRZI decode: decoded = 1 when d_line == prev_line, else 0. prev_line <= d_line on every accepted sample, including stuffed bits.
- All outputs are registered. bit_valid/byte_done assert in the cycle after the accepted sample_en. din_out updates in that same cycle.
- FSM states: IDLE, RECEIVE, STUFF.
  - IDLE: samples ignored; prev_line=IDLE_LINE; ones_cnt=0; bit_cnt=0. Go to RECEIVE when rx_active=1. The sample_en in that same cycle is already accepted.
  - RECEIVE, on sample_en:
    - Emit the decoded bit: bit_valid=1.
    - decoded=1: ones_cnt+1. If that reaches STUFF_LEN, go to STUFF.
    - decoded=0: ones_cnt=0.
    - bit_cnt increments mod 8. byte_done=1 when bit_cnt wraps from 7 to 0.
  - STUFF, on sample_en:
    - Bit is never emitted: no bit_valid, bit_cnt unchanged.
    - decoded=0: legal stuff bit, ones_cnt=0, return to RECEIVE.
    - decoded=1: stuff_error<=1, ones_cnt=0, return to RECEIVE.
  - Any state with rx_active=0: go to IDLE next cycle. A sample_en in a cycle with rx_active=0 is ignored. stuff_error is not cleared by rx_active.
- clear: stuff_error<=0 and bit_cnt<=0 next cycle. If clear and a stuff-error set occur in the same cycle, set wins. clear has no effect on state, ones_cnt or prev_line.
- Without sample_en, state, counters and din_out hold; bit_valid and byte_done are 0.
- Back-to-back sample_en on consecutive cycles is legal and handled at full rate.
- Reset mid-packet: immediate return to reset values. Resume only after rx_active is seen high in IDLE.

Test Plan:
1. Reset, then rx_active=1 and 8 samples with d_line=0,1,0,1,0,1,0,1 -> 8 bit_valid pulses, din_out=0 each, byte_done only on the 8th, stuff_error=0.
2. rx_active=1, d_line held 1 for 6 samples, then 0 for 1 sample, then 0 for 1 sample -> 6 ones emitted, 7th sample dropped (no bit_valid), 8th emitted as din_out=1, ones_cnt restarted, stuff_error=0.
3. d_line held 1 for 7 samples -> 6 bit_valid with din_out=1, stuff_error=1 after the 7th sample. Then pulse clear -> stuff_error=0 next cycle.
4. Feed bits 0x1023456789ABCDEF LSB-first, then CRC 0x01B9 MSB-first, NRZI-encoded with stuffing inserted, into crc_checker_16bit, gated by bit_valid -> crcError=0, stuff_error=0. Corrupt one CRC bit -> crcError=1.
5. Drop rx_active after 5 bits, reassert, send 8 bits -> byte_done on the 8th new bit (bit_cnt restarted), prev_line back to IDLE_LINE.
6. Assert nRst after 3 bits mid-packet -> all outputs 0 immediately. After release with rx_active high, a new 8-bit sequence decodes correctly.
